// File: rtl/store_addr_fifo_if.sv
// ----------------------------------------------------------------------------
// store_addr_fifo_if : write/read handshake and status bundle for store_addr_fifo
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface store_addr_fifo_if #(
  parameter int unsigned DEPTH_WIDTH = 11,
  parameter int unsigned DATA_WIDTH  = 4
);
  logic [DATA_WIDTH-1:0]  wr_data;
  logic                   wr_en;
  logic                   wr_full;
  logic [DEPTH_WIDTH:0]   wr_water_level;
  logic                   almost_full;
  logic [DATA_WIDTH-1:0]  rd_data;
  logic                   rd_en;
  logic                   rd_empty;
  logic                   almost_empty;

  modport master (
    output wr_data, wr_en, rd_en,
    input  wr_full, wr_water_level, almost_full, rd_data, rd_empty, almost_empty
  );

  modport slave (
    input  wr_data, wr_en, rd_en,
    output wr_full, wr_water_level, almost_full, rd_data, rd_empty, almost_empty
  );
endinterface

`default_nettype wire

// File: rtl/store_addr_fifo.sv
// ----------------------------------------------------------------------------
// store_addr_fifo : single-clock 2^DEPTH_WIDTH x DATA_WIDTH FIFO, registered flags
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module store_addr_fifo #(
  parameter int unsigned DEPTH_WIDTH      = 11,
  parameter int unsigned DATA_WIDTH       = 4,
  parameter int unsigned ALMOST_FULL_NUM  = 1020,
  parameter int unsigned ALMOST_EMPTY_NUM = 4
) (
  input  logic                clk,
  input  logic                rst,
  store_addr_fifo_if.slave    bus
);

  localparam int unsigned          c_depth        = 1 << DEPTH_WIDTH;
  localparam logic [DEPTH_WIDTH:0] c_full_level   = {1'b1, {DEPTH_WIDTH{1'b0}}};
  localparam logic [DEPTH_WIDTH:0] c_af_level     = (DEPTH_WIDTH+1)'(ALMOST_FULL_NUM);
  localparam logic [DEPTH_WIDTH:0] c_ae_level     = (DEPTH_WIDTH+1)'(ALMOST_EMPTY_NUM);

  logic [DATA_WIDTH-1:0]  mem_q [0:c_depth-1];

  logic [DEPTH_WIDTH:0]   wr_ptr_q, wr_ptr_d;
  logic [DEPTH_WIDTH:0]   rd_ptr_q, rd_ptr_d;
  logic [DEPTH_WIDTH:0]   level_q,  level_d;
  logic                   wr_full_q,      wr_full_d;
  logic                   rd_empty_q,     rd_empty_d;
  logic                   almost_full_q,  almost_full_d;
  logic                   almost_empty_q, almost_empty_d;
  logic [DATA_WIDTH-1:0]  rd_data_q;

  logic                   wr_accept;
  logic                   rd_accept;

  // Acceptance is gated by the registered flags, so a read on empty or a
  // write on full is simply dropped in the same cycle as the other side.
  always_comb begin
    wr_accept      = bus.wr_en & ~wr_full_q;
    rd_accept      = bus.rd_en & ~rd_empty_q;
    wr_ptr_d       = wr_ptr_q + {{DEPTH_WIDTH{1'b0}}, wr_accept};
    rd_ptr_d       = rd_ptr_q + {{DEPTH_WIDTH{1'b0}}, rd_accept};
    level_d        = wr_ptr_d - rd_ptr_d;
    wr_full_d      = (level_d == c_full_level);
    rd_empty_d     = (level_d == '0);
    almost_full_d  = (level_d >= c_af_level);
    almost_empty_d = (level_d <= c_ae_level);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      level_q        <= '0;
      wr_full_q      <= 1'b0;
      rd_empty_q     <= 1'b1;
      almost_full_q  <= 1'b0;
      almost_empty_q <= 1'b1;
      rd_data_q      <= '0;
    end else begin
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      level_q        <= level_d;
      wr_full_q      <= wr_full_d;
      rd_empty_q     <= rd_empty_d;
      almost_full_q  <= almost_full_d;
      almost_empty_q <= almost_empty_d;
      if (rd_accept) begin
        rd_data_q <= mem_q[rd_ptr_q[DEPTH_WIDTH-1:0]];
      end
    end
  end

  // Storage is left unreset so it can map onto block RAM.
  always_ff @(posedge clk) begin
    if (wr_accept) begin
      mem_q[wr_ptr_q[DEPTH_WIDTH-1:0]] <= bus.wr_data;
    end
  end

  assign bus.wr_full        = wr_full_q;
  assign bus.rd_empty       = rd_empty_q;
  assign bus.almost_full    = almost_full_q;
  assign bus.almost_empty   = almost_empty_q;
  assign bus.wr_water_level = level_q;
  assign bus.rd_data        = rd_data_q;

endmodule

`default_nettype wire

// File: tb/tb_store_addr_fifo.sv
// ----------------------------------------------------------------------------
// tb_store_addr_fifo : directed self-checking bench for store_addr_fifo
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_store_addr_fifo;

  logic clk;
  logic rst;
  int   n_vec;
  int   n_err;

  logic [3:0] model_q [$];
  logic [3:0] exp_rd;

  store_addr_fifo_if #(.DEPTH_WIDTH(11), .DATA_WIDTH(4)) bus ();

  store_addr_fifo #(
    .DEPTH_WIDTH      (11),
    .DATA_WIDTH       (4),
    .ALMOST_FULL_NUM  (1020),
    .ALMOST_EMPTY_NUM (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected {wr_full, almost_full, rd_empty, almost_empty} for a fill level.
  function automatic logic [3:0] flags_for(input int lvl);
    return {lvl == 2048, lvl >= 1020, lvl == 0, lvl <= 4};
  endfunction

  function automatic logic [3:0] flags_now();
    return {bus.wr_full, bus.almost_full, bus.rd_empty, bus.almost_empty};
  endfunction

  // One clock of stimulus, launched and sampled on falling edges; the queue
  // tracks what the FIFO should contain.
  task automatic drive(input logic wr, input logic rd, input logic [3:0] d);
    int lvl;
    lvl = model_q.size();
    bus.wr_en   = wr;
    bus.rd_en   = rd;
    bus.wr_data = d;
    if (rd && lvl > 0) exp_rd = model_q.pop_front();
    if (wr && lvl < 2048) model_q.push_back(d);
    @(negedge clk);
    bus.wr_en = 1'b0;
    bus.rd_en = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    bus.wr_en = 1'b0; bus.rd_en = 1'b0; bus.wr_data = '0;
    exp_rd = 4'h0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_vec++;
    if (flags_now() !== 4'b0011) begin
      n_err++; $display("FAIL reset_flags: got %b expected 0011", flags_now());
    end
    n_vec++;
    if (bus.wr_water_level !== 12'd0) begin
      n_err++; $display("FAIL reset_level: got %0d expected 0", bus.wr_water_level);
    end
    n_vec++;
    if (bus.rd_data !== 4'h0) begin
      n_err++; $display("FAIL reset_rd_data: got %h expected 0", bus.rd_data);
    end
  endtask

  task automatic test_fill();
    int lvl;
    for (int i = 0; i < 2049; i++) begin
      drive(1'b1, 1'b0, 4'hF - 4'(i));
      lvl = (i + 1 > 2048) ? 2048 : i + 1;
      n_vec++;
      if (bus.wr_water_level !== 12'(lvl)) begin
        n_err++; $display("FAIL fill_level wr#%0d: got %0d expected %0d", i + 1, bus.wr_water_level, lvl);
      end
      n_vec++;
      if (flags_now() !== flags_for(lvl)) begin
        n_err++; $display("FAIL fill_flags wr#%0d: got %b expected %b", i + 1, flags_now(), flags_for(lvl));
      end
    end
  endtask

  task automatic test_drain();
    int lvl;
    logic [3:0] exp;
    for (int i = 0; i < 2049; i++) begin
      drive(1'b0, 1'b1, 4'h0);
      lvl = (i + 1 > 2048) ? 0 : 2048 - (i + 1);
      exp = (i < 2048) ? 4'hF - 4'(i) : 4'h0;
      n_vec++;
      if (bus.rd_data !== exp) begin
        n_err++; $display("FAIL drain_data rd#%0d: got %h expected %h", i + 1, bus.rd_data, exp);
      end
      n_vec++;
      if (bus.wr_water_level !== 12'(lvl) || flags_now() !== flags_for(lvl)) begin
        n_err++; $display("FAIL drain_status rd#%0d: got lvl %0d flags %b expected lvl %0d flags %b",
                          i + 1, bus.wr_water_level, flags_now(), lvl, flags_for(lvl));
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] held;
    for (int i = 0; i < 10; i++) drive(1'b1, 1'b0, 4'(i + 3));
    for (int i = 0; i < 100; i++) begin
      drive(1'b1, 1'b1, 4'(i * 7));
      n_vec++;
      if (bus.wr_water_level !== 12'd10 || bus.rd_data !== exp_rd) begin
        n_err++; $display("FAIL b2b cyc %0d: got lvl %0d data %h expected lvl 10 data %h",
                          i, bus.wr_water_level, bus.rd_data, exp_rd);
      end
    end
    for (int i = 0; i < 10; i++) begin
      drive(1'b0, 1'b1, 4'h0);
      n_vec++;
      if (bus.rd_data !== exp_rd) begin
        n_err++; $display("FAIL b2b_drain rd#%0d: got %h expected %h", i, bus.rd_data, exp_rd);
      end
    end
    held = exp_rd;
    drive(1'b1, 1'b1, 4'h6);
    n_vec++;
    if (bus.wr_water_level !== 12'd1 || bus.rd_data !== held || flags_now() !== flags_for(1)) begin
      n_err++; $display("FAIL simul_empty: got lvl %0d data %h flags %b expected lvl 1 data %h flags %b",
                        bus.wr_water_level, bus.rd_data, flags_now(), held, flags_for(1));
    end
    drive(1'b0, 1'b1, 4'h0);
    n_vec++;
    if (bus.rd_data !== 4'h6 || bus.wr_water_level !== 12'd0) begin
      n_err++; $display("FAIL simul_empty_read: got data %h lvl %0d expected data 6 lvl 0",
                        bus.rd_data, bus.wr_water_level);
    end
  endtask

  task automatic test_wrap();
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 1500; i++) drive(1'b1, 1'b0, 4'(i ^ (r * 5 + (i >> 4))));
      n_vec++;
      if (bus.wr_water_level !== 12'd1500 || flags_now() !== flags_for(1500)) begin
        n_err++; $display("FAIL wrap_full round %0d: got lvl %0d flags %b expected lvl 1500 flags %b",
                          r, bus.wr_water_level, flags_now(), flags_for(1500));
      end
      for (int i = 0; i < 1500; i++) begin
        drive(1'b0, 1'b1, 4'h0);
        n_vec++;
        if (bus.rd_data !== exp_rd) begin
          n_err++; $display("FAIL wrap_data round %0d rd#%0d: got %h expected %h", r, i, bus.rd_data, exp_rd);
        end
      end
      n_vec++;
      if (bus.wr_water_level !== 12'd0 || flags_now() !== flags_for(0)) begin
        n_err++; $display("FAIL wrap_empty round %0d: got lvl %0d flags %b expected lvl 0 flags %b",
                          r, bus.wr_water_level, flags_now(), flags_for(0));
      end
    end
  endtask

  task automatic test_async_reset();
    drive(1'b1, 1'b0, 4'h9);
    for (int i = 0; i < 700; i++) drive(1'b1, 1'b0, 4'(i + 1));
    drive(1'b0, 1'b1, 4'h0);
    n_vec++;
    if (bus.wr_water_level !== 12'd700 || bus.rd_data !== 4'h9) begin
      n_err++; $display("FAIL pre_reset: got lvl %0d data %h expected lvl 700 data 9",
                        bus.wr_water_level, bus.rd_data);
    end
    #2 rst = 1'b0;
    #1;
    n_vec++;
    if (bus.wr_water_level !== 12'd0 || flags_now() !== 4'b0011 || bus.rd_data !== 4'h0) begin
      n_err++; $display("FAIL async_reset: got lvl %0d flags %b data %h expected lvl 0 flags 0011 data 0",
                        bus.wr_water_level, flags_now(), bus.rd_data);
    end
    @(negedge clk);
    rst = 1'b1;
    model_q.delete();
    @(negedge clk);
    drive(1'b1, 1'b0, 4'hA);
    n_vec++;
    if (bus.wr_water_level !== 12'd1 || flags_now() !== flags_for(1)) begin
      n_err++; $display("FAIL post_reset_write: got lvl %0d flags %b expected lvl 1 flags %b",
                        bus.wr_water_level, flags_now(), flags_for(1));
    end
    drive(1'b0, 1'b1, 4'h0);
    n_vec++;
    if (bus.rd_data !== 4'hA || bus.wr_water_level !== 12'd0) begin
      n_err++; $display("FAIL post_reset_read: got data %h lvl %0d expected data a lvl 0",
                        bus.rd_data, bus.wr_water_level);
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    test_reset();
    test_fill();
    test_drain();
    test_back_to_back();
    test_wrap();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
